// File: rtl/controller_sequencer.sv
// -----------------------------------------------------------------------------
// controller_sequencer
//
// Purpose:
//    Control unit for a SAP-1 style machine. A six-step ring (T1..T6) runs
//    instruction fetch in T1..T3 and opcode-dependent execute in T4..T6. The
//    control word is a pure Moore decode of the state register, plus the
//    opcode while in T4..T6.
//
// Optional feature (compile-time macro SEQ_SHORT_CYCLE_EN):
//    When defined, execute returns to T1 as soon as an instruction has no
//    further work:
//       OUT and NOP : T4 -> T1
//       LDA         : T5 -> T1
//       ADD / SUB   : unchanged, T6 is required
//    When undefined, every instruction except HLT takes exactly six cycles.
//    HLT behaves identically in both builds.
//
// Ports:
//    i_clock           in   1  system clock, all state changes on rising edge
//    i_reset           in   1  synchronous, active-high reset
//    i_debug           in   1  trace request for simulation; no functional effect
//    i_opcode          in   4  instruction register upper nibble, stable T4..T6
//    o_t_state         out  6  one-hot ring, bit0 = T1 .. bit5 = T6; 0 otherwise
//    o_pc_increment    out  1  Cp  program counter increment
//    o_pc_enable_out   out  1  Ep  program counter drives bus
//    o_mar_load        out  1  Lm  memory address register load
//    o_ram_enable_out  out  1  CE  RAM drives bus
//    o_ir_load         out  1  Li  instruction register load
//    o_ir_enable_out   out  1  Ei  operand nibble drives bus
//    o_a_load          out  1  La  accumulator load
//    o_a_enable_out    out  1  Ea  accumulator drives bus
//    o_alu_subtract    out  1  Su  ALU subtract select
//    o_alu_enable_out  out  1  Eu  ALU result drives bus
//    o_b_load          out  1  Lb  B register load
//    o_out_load        out  1  Lo  output register load
//    o_halt            out  1  high in T4 of HLT and while halted
// -----------------------------------------------------------------------------
module controller_sequencer (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_debug,
   input  logic [3:0] i_opcode,
   output logic [5:0] o_t_state,
   output logic       o_pc_increment,
   output logic       o_pc_enable_out,
   output logic       o_mar_load,
   output logic       o_ram_enable_out,
   output logic       o_ir_load,
   output logic       o_ir_enable_out,
   output logic       o_a_load,
   output logic       o_a_enable_out,
   output logic       o_alu_subtract,
   output logic       o_alu_enable_out,
   output logic       o_b_load,
   output logic       o_out_load,
   output logic       o_halt
);

   // --------------------------------------------------------------------------
   // Opcodes
   // --------------------------------------------------------------------------
   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // --------------------------------------------------------------------------
   // State encoding. T1..T6 are consecutive so the ring output can be derived
   // by comparing against ST_T1 + n.
   // --------------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_T1     = 3'd1;
   localparam logic [2:0] ST_T2     = 3'd2;
   localparam logic [2:0] ST_T3     = 3'd3;
   localparam logic [2:0] ST_T4     = 3'd4;
   localparam logic [2:0] ST_T5     = 3'd5;
   localparam logic [2:0] ST_T6     = 3'd6;
   localparam logic [2:0] ST_HALTED = 3'd7;

   logic [2:0] state_reg;
   logic [2:0] state_next;

   // --------------------------------------------------------------------------
   // Opcode decode. Anything not explicitly recognised executes as a NOP.
   // --------------------------------------------------------------------------
   logic op_lda;
   logic op_add;
   logic op_sub;
   logic op_out;
   logic op_hlt;
   logic op_nop;

   assign op_lda = (i_opcode == OP_LDA);
   assign op_add = (i_opcode == OP_ADD);
   assign op_sub = (i_opcode == OP_SUB);
   assign op_out = (i_opcode == OP_OUT);
   assign op_hlt = (i_opcode == OP_HLT);
   assign op_nop = ~(op_lda | op_add | op_sub | op_out | op_hlt);

   // --------------------------------------------------------------------------
   // Early-exit conditions for the short-cycle build. In the default build
   // both are tied low and the ring always runs to T6.
   // --------------------------------------------------------------------------
   logic t4_done;
   logic t5_done;

`ifdef SEQ_SHORT_CYCLE_EN
   assign t4_done = op_out | op_nop;
   assign t5_done = op_lda;
`else
   assign t4_done = 1'b0;
   assign t5_done = 1'b0;
`endif

   // The trace request only matters to a simulation harness; the sequencer
   // itself never looks at it.
   logic debug_unused;
   assign debug_unused = i_debug;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         // One dead cycle after reset before fetch begins, so downstream
         // registers have settled.
         ST_IDLE: state_next = ST_T1;
         ST_T1:   state_next = ST_T2;
         ST_T2:   state_next = ST_T3;
         ST_T3:   state_next = ST_T4;
         ST_T4: begin
            if (op_hlt) begin
               state_next = ST_HALTED;
            end else if (t4_done) begin
               state_next = ST_T1;
            end else begin
               state_next = ST_T5;
            end
         end
         ST_T5: begin
            if (t5_done) begin
               state_next = ST_T1;
            end else begin
               state_next = ST_T6;
            end
         end
         ST_T6:     state_next = ST_T1;
         // Only reset leaves HALTED.
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // State register. Reset wins from every state, including mid-execute and
   // HALTED.
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // --------------------------------------------------------------------------
   // Ring counter view of the state: one bit per T-step, all zero in IDLE and
   // HALTED.
   // --------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi = gi + 1) begin : g_t_state
         assign o_t_state[gi] = (state_reg == 3'(gi + 1));
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Control word decode. Bus drivers (Ep, CE, Ei, Ea, Eu) are each asserted
   // in a distinct state/opcode slot, so no two can be on together.
   // --------------------------------------------------------------------------
   always_comb begin
      o_pc_increment   = 1'b0;
      o_pc_enable_out  = 1'b0;
      o_mar_load       = 1'b0;
      o_ram_enable_out = 1'b0;
      o_ir_load        = 1'b0;
      o_ir_enable_out  = 1'b0;
      o_a_load         = 1'b0;
      o_a_enable_out   = 1'b0;
      o_alu_subtract   = 1'b0;
      o_alu_enable_out = 1'b0;
      o_b_load         = 1'b0;
      o_out_load       = 1'b0;
      o_halt           = 1'b0;

      case (state_reg)
         // Fetch: address phase.
         ST_T1: begin
            o_pc_enable_out = 1'b1;
            o_mar_load      = 1'b1;
         end

         // Fetch: a single-cycle increment gives exactly one PC edge per
         // instruction.
         ST_T2: begin
            o_pc_increment = 1'b1;
         end

         // Fetch: memory phase into the instruction register.
         ST_T3: begin
            o_ram_enable_out = 1'b1;
            o_ir_load        = 1'b1;
         end

         ST_T4: begin
            if (op_lda | op_add | op_sub) begin
               // Operand address to MAR.
               o_ir_enable_out = 1'b1;
               o_mar_load      = 1'b1;
            end else if (op_out) begin
               o_a_enable_out = 1'b1;
               o_out_load     = 1'b1;
            end else if (op_hlt) begin
               o_halt = 1'b1;
            end
         end

         ST_T5: begin
            if (op_lda) begin
               o_ram_enable_out = 1'b1;
               o_a_load         = 1'b1;
            end else if (op_add | op_sub) begin
               o_ram_enable_out = 1'b1;
               o_b_load         = 1'b1;
               // Subtract is set up a cycle early so the ALU result has
               // settled by the time it is driven onto the bus in T6.
               o_alu_subtract   = op_sub;
            end
         end

         ST_T6: begin
            if (op_add | op_sub) begin
               o_alu_enable_out = 1'b1;
               o_a_load         = 1'b1;
               o_alu_subtract   = op_sub;
            end
         end

         ST_HALTED: begin
            o_halt = 1'b1;
         end

         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_controller_sequencer.sv
// -----------------------------------------------------------------------------
// tb_controller_sequencer
//
// Randomised bench for controller_sequencer. The reference model works at the
// instruction level: each instruction is a list of control words (its
// microprogram) with a length that depends on the opcode and build, and the
// model simply steps through that list. A directed prefix walks LDA, SUB, ADD,
// OUT, a NOP opcode, a reset in T5 of ADD and a 20-cycle halt before random
// traffic takes over.
// -----------------------------------------------------------------------------
module tb_controller_sequencer;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Control word bit positions used by the model.
   localparam logic [12:0] CP   = 13'h0001;
   localparam logic [12:0] EP   = 13'h0002;
   localparam logic [12:0] LM   = 13'h0004;
   localparam logic [12:0] CE   = 13'h0008;
   localparam logic [12:0] LI   = 13'h0010;
   localparam logic [12:0] EI   = 13'h0020;
   localparam logic [12:0] LA   = 13'h0040;
   localparam logic [12:0] EA   = 13'h0080;
   localparam logic [12:0] SU   = 13'h0100;
   localparam logic [12:0] EU   = 13'h0200;
   localparam logic [12:0] LB   = 13'h0400;
   localparam logic [12:0] LO   = 13'h0800;
   localparam logic [12:0] HALT = 13'h1000;

   localparam int NUM_CYCLES = 2500;

   logic       i_clock = 1'b0;
   logic       i_reset;
   logic       i_debug;
   logic [3:0] i_opcode;
   logic [5:0] o_t_state;
   logic       o_pc_increment;
   logic       o_pc_enable_out;
   logic       o_mar_load;
   logic       o_ram_enable_out;
   logic       o_ir_load;
   logic       o_ir_enable_out;
   logic       o_a_load;
   logic       o_a_enable_out;
   logic       o_alu_subtract;
   logic       o_alu_enable_out;
   logic       o_b_load;
   logic       o_out_load;
   logic       o_halt;

   controller_sequencer dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_debug          (i_debug),
      .i_opcode         (i_opcode),
      .o_t_state        (o_t_state),
      .o_pc_increment   (o_pc_increment),
      .o_pc_enable_out  (o_pc_enable_out),
      .o_mar_load       (o_mar_load),
      .o_ram_enable_out (o_ram_enable_out),
      .o_ir_load        (o_ir_load),
      .o_ir_enable_out  (o_ir_enable_out),
      .o_a_load         (o_a_load),
      .o_a_enable_out   (o_a_enable_out),
      .o_alu_subtract   (o_alu_subtract),
      .o_alu_enable_out (o_alu_enable_out),
      .o_b_load         (o_b_load),
      .o_out_load       (o_out_load),
      .o_halt           (o_halt)
   );

   always #5 i_clock = ~i_clock;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_cnt++;
      if (observed !== expected) begin
         fail_cnt++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   // Microprogram word for a given step (0 = T1 .. 5 = T6) of an instruction.
   function automatic logic [12:0] micro_word(input logic [3:0] op, input int step);
      logic [12:0] w;
      w = '0;
      case (step)
         0: w = EP | LM;
         1: w = CP;
         2: w = CE | LI;
         default: begin
            case (op)
               OP_LDA: w = (step == 3) ? (EI | LM) : (step == 4) ? (CE | LA) : 13'h0;
               OP_ADD: w = (step == 3) ? (EI | LM) : (step == 4) ? (CE | LB) : (EU | LA);
               OP_SUB: w = (step == 3) ? (EI | LM) : (step == 4) ? (CE | LB | SU) : (EU | LA | SU);
               OP_OUT: w = (step == 3) ? (EA | LO) : 13'h0;
               OP_HLT: w = (step == 3) ? HALT : 13'h0;
               default: w = '0;
            endcase
         end
      endcase
      return w;
   endfunction

   // Number of T-steps an instruction occupies before the next T1.
   function automatic int instr_len(input logic [3:0] op);
      int len;
      len = 6;
`ifdef SEQ_SHORT_CYCLE_EN
      if (op == OP_LDA) len = 5;
      else if (op == OP_ADD || op == OP_SUB) len = 6;
      else len = 4;
`endif
      if (op == OP_HLT) len = 4;
      return len;
   endfunction

   // Model state: 0 = idle, 1 = running an instruction, 2 = halted.
   int          mode;
   int          step;
   logic [3:0]  cur_op;
   int          halt_cycles;
   int          halt_target;
   bit          mid_reset_done;
   bit          do_reset;
   logic [3:0]  plan[$];
   logic [12:0] exp_ctrl;
   logic [5:0]  exp_t;
   logic [12:0] got_ctrl;
   int          bus_drivers;
   int          instr_count;

   task automatic start_instr();
      int pick;
      if (plan.size() > 0) begin
         cur_op = plan.pop_front();
      end else begin
         pick = $urandom_range(0, 9);
         case (pick)
            0, 1: cur_op = OP_LDA;
            2, 3: cur_op = OP_ADD;
            4, 5: cur_op = OP_SUB;
            6:    cur_op = OP_OUT;
            7:    cur_op = OP_HLT;
            default: cur_op = 4'($urandom_range(0, 15));
         endcase
      end
      step = 0;
      mode = 1;
      instr_count++;
      $display("instr %0d: opcode %b at %0t", instr_count, cur_op, $time);
   endtask

   task automatic compare_outputs(input string tag);
      if (mode == 1) begin
         exp_t    = 6'(1 << step);
         exp_ctrl = micro_word(cur_op, step);
      end else if (mode == 2) begin
         exp_t    = '0;
         exp_ctrl = HALT;
      end else begin
         exp_t    = '0;
         exp_ctrl = '0;
      end
      got_ctrl = {o_halt, o_out_load, o_b_load, o_alu_enable_out, o_alu_subtract,
                  o_a_enable_out, o_a_load, o_ir_enable_out, o_ir_load,
                  o_ram_enable_out, o_mar_load, o_pc_enable_out, o_pc_increment};
      bus_drivers = int'(o_pc_enable_out) + int'(o_ram_enable_out) + int'(o_ir_enable_out)
                  + int'(o_a_enable_out) + int'(o_alu_enable_out);
      check_value({tag, "_t_state"}, 32'(o_t_state), 32'(exp_t));
      check_value({tag, "_ctrl"}, 32'(got_ctrl), 32'(exp_ctrl));
      check_value({tag, "_bus_excl"}, 32'(bus_drivers <= 1), 32'd1);
   endtask

   initial begin
      mode           = 0;
      step           = 0;
      cur_op         = '0;
      halt_cycles    = 0;
      halt_target    = 20;
      mid_reset_done = 1'b0;
      instr_count    = 0;
      plan.push_back(OP_LDA);
      plan.push_back(OP_SUB);
      plan.push_back(OP_ADD);   // aborted by reset in T5
      plan.push_back(OP_ADD);
      plan.push_back(OP_OUT);
      plan.push_back(4'b0111);
      plan.push_back(OP_HLT);

      i_reset  = 1'b1;
      i_debug  = 1'b0;
      i_opcode = OP_HLT;
      repeat (2) @(posedge i_clock);
      #1;
      @(negedge i_clock);
      compare_outputs("reset");

      for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
         // Decide reset for the coming edge.
         do_reset = 1'b0;
         if (mode == 2) begin
            if (halt_cycles >= halt_target) do_reset = 1'b1;
         end else if (mode == 1 && cur_op == OP_ADD && step == 4 && !mid_reset_done) begin
            do_reset       = 1'b1;
            mid_reset_done = 1'b1;
         end else if (mode == 1 && $urandom_range(0, 149) == 0) begin
            do_reset = 1'b1;
         end
         i_reset = do_reset;
         i_debug = 1'($urandom_range(0, 1));

         @(posedge i_clock);

         if (do_reset) begin
            mode = 0;
         end else begin
            case (mode)
               0: start_instr();
               1: begin
                  if (cur_op == OP_HLT && step == 3) begin
                     mode        = 2;
                     halt_cycles = 1;
                  end else begin
                     step++;
                     if (step >= instr_len(cur_op)) start_instr();
                  end
               end
               default: halt_cycles++;
            endcase
            if (mode == 2 && halt_cycles == 1 && halt_target == 20 && instr_count > 7)
               halt_target = $urandom_range(2, 25);
         end

         #1;
         // Opcode only matters in execute; elsewhere it is random noise.
         if (mode == 1 && step >= 3) i_opcode = cur_op;
         else i_opcode = 4'($urandom_range(0, 15));

         @(negedge i_clock);
         compare_outputs("cyc");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
